// File: rtl/udp_tx_sched.sv
// udp_tx_sched: round-robin frame scheduler in front of the single UDP packet
// generator. Each client raises a level request. The scheduler picks one
// client, latches its payload length (clamped) and its destination port, and
// pulses the generator start. It follows the generator ready flag through one
// complete frame, then holds an inter-frame gap before it grants again.
//
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   req           - per-client level request (NUM_REQ bits)
//   req_len       - per-client payload length, client k at [16k+15:16k]
//   req_port      - per-client UDP destination port, same packing
//   gnt           - one-hot grant, held from grant until frame end
//   done          - one-cycle pulse on the granted bit at frame end
//   gen_enable    - one-cycle start pulse to the generator
//   gen_len       - clamped payload length for the granted client
//   gen_dst_port  - destination port for the granted client
//   gen_ready     - generator idle/ready flag
//   busy          - high whenever the scheduler is not idle
//   timeout_err   - sticky flag, set on an ACK or frame timeout
module udp_tx_sched #(
    parameter int          NUM_REQ       = 4,
    parameter logic [15:0] MIN_LEN       = 16'd18,
    parameter logic [15:0] MAX_LEN       = 16'd1472,
    parameter logic [15:0] IFG_CYCLES    = 16'd12,
    parameter logic [15:0] ACK_TIMEOUT   = 16'd64,
    parameter logic [31:0] FRAME_TIMEOUT = 32'd100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*16-1:0]   req_len,
    input  logic [NUM_REQ*16-1:0]   req_port,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic                    gen_enable,
    output logic [15:0]             gen_len,
    output logic [15:0]             gen_dst_port,
    input  logic                    gen_ready,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Limits widened once so every counter compare is a plain 32-bit compare.
    localparam logic [31:0] ACK_LIM = {16'd0, ACK_TIMEOUT};
    localparam logic [31:0] IFG_LIM = {16'd0, IFG_CYCLES};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ACK,
        ST_BUSY,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               gen_enable_q, gen_enable_d;
    logic [15:0]        gen_len_q, gen_len_d;
    logic [15:0]        gen_dst_port_q, gen_dst_port_d;
    logic               timeout_err_q, timeout_err_d;
    // One counter serves ACK wait, frame wait and gap; it restarts on every
    // state entry, so the three uses never overlap.
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        cnt_inc;

    // Per-client fields unpacked so the winner can be picked by a narrow index.
    logic [15:0]        len_arr  [NUM_REQ];
    logic [15:0]        port_arr [NUM_REQ];

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    int                 arb_sum;

    function automatic logic [15:0] clamp_len(input logic [15:0] len);
        if (len < MIN_LEN) begin
            return MIN_LEN;
        end else if (len > MAX_LEN) begin
            return MAX_LEN;
        end
        return len;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            len_arr[k]  = req_len[16*k +: 16];
            port_arr[k] = req_port[16*k +: 16];
        end
    end

    // Rotating priority: search upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_sum = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            arb_sum = int'(rr_ptr_q) + i;
            if (arb_sum >= NUM_REQ) begin
                arb_sum = arb_sum - NUM_REQ;
            end
            if (!win_vld && req[arb_sum[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = arb_sum[PTR_W-1:0];
            end
        end
    end

    assign cnt_inc = sat_inc(cnt_q);

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        done_d         = '0;
        gen_enable_d   = 1'b0;
        gen_len_d      = gen_len_q;
        gen_dst_port_d = gen_dst_port_q;
        timeout_err_d  = timeout_err_q;
        cnt_d          = cnt_inc;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (win_vld) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    gen_len_d      = clamp_len(len_arr[win_idx]);
                    gen_dst_port_d = port_arr[win_idx];
                    rr_ptr_d       = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0
                                                                      : win_idx + PTR_W'(1);
                    state_d        = ST_START;
                end
            end
            ST_START: begin
                cnt_d = '0;
                if (gen_ready) begin
                    gen_enable_d = 1'b1;
                    state_d      = ST_ACK;
                end
            end
            ST_ACK: begin
                // The generator acknowledges the start by dropping ready.
                if (!gen_ready) begin
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else if (cnt_inc >= ACK_LIM) begin
                    timeout_err_d = 1'b1;
                    done_d        = gnt_q;
                    gnt_d         = '0;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end
            end
            ST_BUSY: begin
                if (gen_ready) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else if (cnt_inc >= FRAME_TIMEOUT) begin
                    timeout_err_d = 1'b1;
                    done_d        = gnt_q;
                    gnt_d         = '0;
                    cnt_d         = '0;
                    state_d       = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_inc >= IFG_LIM) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            gnt_q          <= '0;
            done_q         <= '0;
            gen_enable_q   <= 1'b0;
            gen_len_q      <= '0;
            gen_dst_port_q <= '0;
            timeout_err_q  <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            gen_enable_q   <= gen_enable_d;
            gen_len_q      <= gen_len_d;
            gen_dst_port_q <= gen_dst_port_d;
            timeout_err_q  <= timeout_err_d;
            cnt_q          <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign gen_enable   = gen_enable_q;
    assign gen_len      = gen_len_q;
    assign gen_dst_port = gen_dst_port_q;
    assign timeout_err  = timeout_err_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Round-robin frame scheduler that shares the single UDP packet generator between NUM_REQ client streams.
- Latches the winning client's payload length and destination port, and pulses the generator's start input.
- Tracks the generator's ready flag through one whole frame, then enforces a minimum inter-frame gap before the next grant.
- Sits between the acquisition-side producers and the generator/MAC path.

Parameters:
- NUM_REQ, 4, number of requesting clients (2..8)
- MIN_LEN, 16'd18, smallest payload length passed to the generator
- MAX_LEN, 16'd1472, largest payload length passed to the generator
- IFG_CYCLES, 16'd12, idle clocks enforced after each frame completes
- ACK_TIMEOUT, 16'd64, clocks allowed for the generator to drop ready after start
- FRAME_TIMEOUT, 32'd100000, clocks allowed for the generator to raise ready again

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-client frame request, level
- req_len  in  NUM_REQ*16  per-client payload length; client k uses bits [16k+15:16k]
- req_port  in  NUM_REQ*16  per-client UDP destination port, same packing as req_len
- gnt  out  NUM_REQ  one-hot grant, held from grant until frame end
- done  out  NUM_REQ  one-cycle pulse on the granted bit at frame end
- gen_enable  out  1  one-cycle start pulse to the generator
- gen_len  out  16  clamped payload length, stable while gnt != 0
- gen_dst_port  out  16  destination port, stable while gnt != 0
- gen_ready  in  1  generator idle/ready flag (high = ready for a new frame)
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky error flag; cleared only by rst

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; rr_ptr=0.
  - gnt=0, done=0, gen_enable=0, gen_len=0, gen_dst_port=0, busy=0, timeout_err=0.
  - Reset mid-frame abandons the frame immediately; no done pulse is issued.
- States: IDLE, START, ACK, BUSY, GAP.
- IDLE:
  - If req != 0, select the first set bit searching upward from rr_ptr with wrap-around.
  - At the next edge: register gnt (one-hot), gen_len and gen_dst_port; set rr_ptr = winner+1 mod NUM_REQ; go to START.
  - If req == 0, stay in IDLE.
- Length clamp: gen_len = MIN_LEN if req_len < MIN_LEN; MAX_LEN if req_len > MAX_LEN; otherwise req_len. Unsigned 16-bit compare.
- START:
  - Wait for gen_ready=1.
  - The edge that samples gen_ready=1 sets gen_enable=1 for exactly one cycle, clears the ACK counter, and goes to ACK.
- ACK:
  - gen_ready=0 -> go to BUSY and clear the frame counter.
  - Counter reaches ACK_TIMEOUT -> set timeout_err, pulse done, go to GAP.
- BUSY:
  - gen_ready=1 -> pulse done[winner], clear gnt, go to GAP.
  - Counter reaches FRAME_TIMEOUT -> set timeout_err, pulse done, clear gnt, go to GAP.
- GAP:
  - Hold IFG_CYCLES clocks with gnt=0, then return to IDLE.
  - With IFG_CYCLES=0, go to IDLE on the next edge.
- Request sampling and withdrawal:
  - req, req_len and req_port are sampled only in IDLE.
  - Deasserting req after the grant does not cancel the frame.
  - Changing req_len while granted has no effect.
- A client holding req high continuously is re-served only after every other active requester has had a turn.
- Minimum latency:
  - req rises at edge T with gen_ready=1 -> gnt valid after T+1, gen_enable high during T+2.
  - done is a single pulse, coincident with gnt clearing.
- Invariants:
  - gnt is one-hot or zero at all times.
  - gen_enable never asserts outside START->ACK.
  - done is never asserted together with gen_enable.
  - Timeout counters are 16/32-bit saturating and are reset on each state entry.

Test Plan:
- Single client: rst, then req=4'b0001, req_len=1040, req_port=16'hC360, gen model drops ready 3 cycles after start and raises it 1100 cycles later -> gnt=0001 at T+1, gen_enable one pulse at T+2, gen_len=1040, gen_dst_port=C360, done[0] pulse, then 12 GAP cycles.
- Round-robin: req=4'b1111 held for 5 frames -> grant order 0,1,2,3,0; no done or gnt overlap.
- Clamp: req_len=5 -> gen_len=18; req_len=2000 -> gen_len=1472; req_len=18 -> 18; req_len=1472 -> 1472.
- Ready stall: gen_ready=0 when the grant is issued -> stays in START, no gen_enable until gen_ready=1; then exactly one pulse.
- Timeouts: gen_ready never drops after start -> after 64 cycles timeout_err=1, done pulse, GAP then IDLE; a second frame still completes with timeout_err still 1.
- Reset mid-frame: assert rst in BUSY -> next edge gnt=0, done=0, busy=0, timeout_err=0; a fresh req on client 2 is granted first (rr_ptr=0 search finds 2).
